// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode and FSM state encodings shared by iter_alu and alu_core
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational single-cycle ALU ops and result flags
// Rev 1.0
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             carry_o,
  output logic             illegal_o
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;

  // ADD and SUB share one adder: SUB is A + ~B + 1
  assign sub     = (op_i == OP_SUB);
  assign b_eff   = sub ? ~b_i : b_i;
  assign sum     = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign add_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    res_o      = '0;
    overflow_o = 1'b0;
    carry_o    = 1'b0;
    illegal_o  = 1'b0;
    case (op_i)
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_NOR: res_o = ~(a_i | b_i);
      OP_ADD, OP_SUB: begin
        res_o      = sum[WIDTH-1:0];
        overflow_o = add_ovf;
        carry_o    = sum[WIDTH];
      end
      OP_SLT: res_o[0] = ($signed(a_i) < $signed(b_i));
      // MUL is sequenced by the parent; here it only decides legality
      OP_MUL: illegal_o = (MUL_EN == 0);
      default: illegal_o = 1'b1;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule
`default_nettype wire

// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// iter_alu : valid/ready ALU with single-cycle ops and iterative shift-add MUL
// Rev 1.0
// ============================================================================
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_q, state_d;
  logic               accept, is_mul, mul_last;
  logic [WIDTH-1:0]   core_res;
  logic               core_zero, core_ovf, core_cout, core_illegal;
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_step;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q, ovf_q, cout_q, illegal_q;

  alu_core #(.WIDTH(WIDTH), .MUL_EN(MUL_EN)) u_core (
    .a_i        (input0),
    .b_i        (input1),
    .op_i       (alu_control),
    .res_o      (core_res),
    .zero_o     (core_zero),
    .overflow_o (core_ovf),
    .carry_o    (core_cout),
    .illegal_o  (core_illegal)
  );

  assign accept   = in_valid && in_ready;
  assign is_mul   = (MUL_EN != 0) && (alu_control == OP_MUL);
  assign mul_last = (cnt_q == CW'(WIDTH - 1));
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept)                                state_d = is_mul ? ST_MUL : ST_DONE;
        else if (state_q == ST_DONE && out_ready)  state_d = ST_IDLE;
      end
      ST_MUL:  if (mul_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
    out_valid = (state_q == ST_DONE);
  end

  // Result registers change only on acceptance or MUL completion, so they hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cout_q    <= 1'b0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, input0};
        mplier_q <= input1;
        cnt_q    <= '0;
      end else begin
        res_q     <= core_res;
        zero_q    <= core_zero;
        ovf_q     <= core_ovf;
        cout_q    <= core_cout;
        illegal_q <= core_illegal;
      end
    end else if (state_q == ST_MUL) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (mul_last) begin
        res_q     <= acc_step[WIDTH-1:0];
        zero_q    <= (acc_step[WIDTH-1:0] == '0);
        ovf_q     <= |acc_step[2*WIDTH-1:WIDTH];
        cout_q    <= 1'b0;
        illegal_q <= 1'b0;
      end
    end
  end

  assign res       = res_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
// tb_iter_alu : directed self-checking bench for iter_alu (64-bit, 8-bit, 8-bit no-MUL)
// Rev 1.0
// ============================================================================
module tb_iter_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or, a_z, a_o, a_c, a_il;
  logic [63:0] a_x, a_y, a_r;
  logic [3:0]  a_op;
  logic        b_iv, b_ir, b_ov, b_or, b_z, b_o, b_c, b_il;
  logic [7:0]  b_x, b_y, b_r;
  logic [3:0]  b_op;
  logic        c_iv, c_ir, c_ov, c_or, c_z, c_o, c_c, c_il;
  logic [7:0]  c_x, c_y, c_r;
  logic [3:0]  c_op;

  int n_vec = 0;
  int n_err = 0;

  iter_alu #(.WIDTH(64), .MUL_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .input0(a_x), .input1(a_y),
    .alu_control(a_op), .out_valid(a_ov), .out_ready(a_or), .res(a_r), .zero(a_z),
    .overflow(a_o), .carry_out(a_c), .illegal(a_il));

  iter_alu #(.WIDTH(8), .MUL_EN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .input0(b_x), .input1(b_y),
    .alu_control(b_op), .out_valid(b_ov), .out_ready(b_or), .res(b_r), .zero(b_z),
    .overflow(b_o), .carry_out(b_c), .illegal(b_il));

  iter_alu #(.WIDTH(8), .MUL_EN(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .input0(c_x), .input1(c_y),
    .alu_control(c_op), .out_valid(c_ov), .out_ready(c_or), .res(c_r), .zero(c_z),
    .overflow(c_o), .carry_out(c_c), .illegal(c_il));

  task automatic drive_a(input logic v, input logic [63:0] x, input logic [63:0] y,
                         input logic [3:0] op, input logic ordy);
    a_iv = v; a_x = x; a_y = y; a_op = op; a_or = ordy;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] op, input logic ordy);
    b_iv = v; b_x = x; b_y = y; b_op = op; b_or = ordy;
  endtask

  // One-shot 64-bit op: returns {out_valid, res, zero, overflow, carry, illegal} one cycle after accept
  task automatic op_a(input logic [63:0] x, input logic [63:0] y, input logic [3:0] op,
                      output logic [68:0] got);
    @(negedge clk); drive_a(1'b1, x, y, op, 1'b0);
    @(posedge clk); #1;
    got = {a_ov, a_r, a_z, a_o, a_c, a_il};
    @(negedge clk); drive_a(1'b0, '0, '0, OP_AND, 1'b1);
    @(negedge clk); a_or = 1'b0;
  endtask

  task automatic test_reset;
    drive_a(1'b0, '0, '0, OP_AND, 1'b0);
    drive_b(1'b0, '0, '0, OP_AND, 1'b0);
    c_iv = 1'b0; c_x = '0; c_y = '0; c_op = OP_AND; c_or = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_vec++;
    if ({a_ov, a_r, a_z, a_o, a_c, a_il} !== 69'd0) begin
      n_err++; $display("FAIL reset64: got %h exp 0", {a_ov, a_r, a_z, a_o, a_c, a_il});
    end
    n_vec++;
    if ({b_ov, b_r, b_z, b_o, b_c, b_il} !== 13'd0) begin
      n_err++; $display("FAIL reset8: got %h exp 0", {b_ov, b_r, b_z, b_o, b_c, b_il});
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_vec++;
    if ({a_ir, b_ir, c_ir} !== 3'b111) begin
      n_err++; $display("FAIL reset_in_ready: got %b exp 111", {a_ir, b_ir, c_ir});
    end
  endtask

  task automatic test_add;
    logic [68:0] got;
    @(negedge clk); drive_a(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, 1'b0);
    #1;
    n_vec++;
    if (a_ov !== 1'b0) begin n_err++; $display("FAIL add_pre_valid: got %b exp 0", a_ov); end
    @(posedge clk); #1;
    got = {a_ov, a_r, a_z, a_o, a_c, a_il};
    n_vec++;
    if (got !== {1'b1, 64'h8000_0000_0000_0000, 4'b0100}) begin
      n_err++; $display("FAIL add_ovf: got %h exp %h", got, {1'b1, 64'h8000_0000_0000_0000, 4'b0100});
    end
    @(negedge clk); drive_a(1'b0, '0, '0, OP_AND, 1'b1);
    @(negedge clk); a_or = 1'b0;
    op_a(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, OP_ADD, got);
    n_vec++;
    if (got !== {1'b1, 64'h1, 4'b0010}) begin
      n_err++; $display("FAIL add_carry: got %h exp %h", got, {1'b1, 64'h1, 4'b0010});
    end
  endtask

  task automatic test_sub;
    logic [68:0] got;
    op_a(64'h35E8_35E0_35EA_35E0, 64'h35E8_35E0_35EA_35E0, OP_SUB, got);
    n_vec++;
    if (got !== {1'b1, 64'h0, 4'b1010}) begin
      n_err++; $display("FAIL sub_equal: got %h exp %h", got, {1'b1, 64'h0, 4'b1010});
    end
    op_a(64'h5, 64'h7, OP_SUB, got);
    n_vec++;
    if (got !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000}) begin
      n_err++; $display("FAIL sub_borrow: got %h exp %h", got, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000});
    end
  endtask

  task automatic test_illegal;
    logic [68:0] got;
    op_a(64'h1234, 64'h5678, 4'b0101, got);
    n_vec++;
    if (got !== {1'b1, 64'h0, 4'b1001}) begin
      n_err++; $display("FAIL illegal_0101: got %h exp %h", got, {1'b1, 64'h0, 4'b1001});
    end
  endtask

  task automatic test_back_to_back;
    logic [69:0] got;
    @(negedge clk); drive_a(1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, OP_AND, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); drive_a(1'b1, 64'h1, 64'h1, OP_ADD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      got = {a_ir, a_ov, a_r, a_z, a_o, a_c, a_il};
      n_vec++;
      if (got !== {1'b0, 1'b1, 64'hF000_F000_F000_F000, 4'b0000}) begin
        n_err++; $display("FAIL hold_%0d: got %h exp %h", i, got, {1'b0, 1'b1, 64'hF000_F000_F000_F000, 4'b0000});
      end
    end
    @(negedge clk); drive_a(1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, OP_OR, 1'b1);
    @(posedge clk); #1;
    got = {a_ir, a_ov, a_r, a_z, a_o, a_c, a_il};
    n_vec++;
    if (got !== {1'b1, 1'b1, 64'hFFF0_FFF0_FFF0_FFF0, 4'b0000}) begin
      n_err++; $display("FAIL b2b_or: got %h exp %h", got, {1'b1, 1'b1, 64'hFFF0_FFF0_FFF0_FFF0, 4'b0000});
    end
    @(negedge clk); drive_a(1'b0, '0, '0, OP_AND, 1'b1);
    @(posedge clk); #1;
    n_vec++;
    if (a_ov !== 1'b0) begin n_err++; $display("FAIL b2b_retire: got %b exp 0", a_ov); end
    @(negedge clk); a_or = 1'b0;
  endtask

  task automatic test_slt;
    logic [7:0]  vx [4] = '{8'hFF, 8'h01, 8'h80, 8'h0F};
    logic [7:0]  vy [4] = '{8'h01, 8'hFF, 8'h7F, 8'hF0};
    logic [3:0]  vo [4] = '{OP_SLT, OP_SLT, OP_SLT, OP_NOR};
    logic [12:0] ve [4] = '{{1'b1, 8'h01, 4'b0000}, {1'b1, 8'h00, 4'b1000},
                            {1'b1, 8'h01, 4'b0000}, {1'b1, 8'h00, 4'b1000}};
    logic [12:0] got;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_b(1'b1, vx[i], vy[i], vo[i], 1'b0);
      @(posedge clk); #1;
      got = {b_ov, b_r, b_z, b_o, b_c, b_il};
      n_vec++;
      if (got !== ve[i]) begin n_err++; $display("FAIL slt_nor_%0d: got %h exp %h", i, got, ve[i]); end
      @(negedge clk); drive_b(1'b0, '0, '0, OP_AND, 1'b1);
      @(negedge clk); b_or = 1'b0;
    end
  endtask

  task automatic test_mul;
    logic [7:0]  vx [3] = '{8'h10, 8'h0F, 8'hFF};
    logic [7:0]  vy [3] = '{8'h11, 8'h0F, 8'hFF};
    logic [11:0] ve [3] = '{{8'h10, 4'b0100}, {8'hE1, 4'b0000}, {8'h01, 4'b0100}};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_b(1'b1, vx[i], vy[i], OP_MUL, 1'b0);
      @(posedge clk); #1;
      b_iv = 1'b0;
      cyc = 1;
      while (!b_ov && cyc < 20) begin
        n_vec++;
        if (b_ir !== 1'b0) begin n_err++; $display("FAIL mul_in_ready_%0d: got %b exp 0", cyc, b_ir); end
        @(posedge clk); #1;
        cyc++;
      end
      n_vec++;
      if (cyc != 9) begin n_err++; $display("FAIL mul_latency_%0d: got %0d exp 9", i, cyc); end
      n_vec++;
      if ({b_r, b_z, b_o, b_c, b_il} !== ve[i]) begin
        n_err++; $display("FAIL mul_res_%0d: got %h exp %h", i, {b_r, b_z, b_o, b_c, b_il}, ve[i]);
      end
      @(negedge clk); drive_b(1'b0, '0, '0, OP_AND, 1'b1);
      @(negedge clk); b_or = 1'b0;
    end
  endtask

  task automatic test_mul_disabled;
    logic [12:0] got;
    @(negedge clk); c_iv = 1'b1; c_x = 8'h03; c_y = 8'h05; c_op = OP_MUL; c_or = 1'b0;
    @(posedge clk); #1;
    got = {c_ov, c_r, c_z, c_o, c_c, c_il};
    n_vec++;
    if (got !== {1'b1, 8'h00, 4'b1001}) begin
      n_err++; $display("FAIL mul_disabled: got %h exp %h", got, {1'b1, 8'h00, 4'b1001});
    end
    @(negedge clk); c_iv = 1'b0; c_or = 1'b1;
    @(negedge clk); c_or = 1'b0;
  endtask

  task automatic test_reset_mid_mul;
    @(negedge clk); drive_b(1'b1, 8'h10, 8'h11, OP_MUL, 1'b0);
    @(posedge clk); #1;
    b_iv = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({b_ov, b_r, b_z, b_o, b_c, b_il} !== 13'd0) begin
      n_err++; $display("FAIL rst_mid_mul: got %h exp 0", {b_ov, b_r, b_z, b_o, b_c, b_il});
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_vec++;
    if (b_ir !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b exp 1", b_ir); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (b_ov !== 1'b0) begin n_err++; $display("FAIL rst_no_result_%0d: got %b exp 0", i, b_ov); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_illegal;
    test_back_to_back;
    test_slt;
    test_mul;
    test_mul_disabled;
    test_reset_mid_mul;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
